gpio_irq_bank: RTL and testbench

- Parametrised successor to the single fixed 8-bit GPIO latch in the 6502 SoC top.
- Provides NPORTS 8-bit GPIO ports, each with a per-pin direction register, synchronised input readback, and per-pin edge interrupts.
- Interrupts are combined into one registered IRQ that drives the core's IRQ input.
- Sits on the CPU bus behind the top-level page decode; read data is registered, so it fits the existing one-cycle-late data mux.

---
 rtl/gpio_irq_pkg.sv | 27 ++
 rtl/gpio_irq_port.sv | 104 ++++++++++
 rtl/gpio_irq_bank.sv | 84 ++++++++
 tb/tb_gpio_irq_bank.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared register map and edge-selection helper for the GPIO interrupt bank.
package gpio_irq_pkg;

  localparam int PORT_W = 3;
  localparam int REG_W  = 3;

  localparam logic [REG_W-1:0] REG_OUT   = 3'd0;
  localparam logic [REG_W-1:0] REG_DIR   = 3'd1;
  localparam logic [REG_W-1:0] REG_IN    = 3'd2;
  localparam logic [REG_W-1:0] REG_IEN   = 3'd3;
  localparam logic [REG_W-1:0] REG_IPOL  = 3'd4;
  localparam logic [REG_W-1:0] REG_ISTAT = 3'd5;
  localparam logic [REG_W-1:0] REG_IBOTH = 3'd6;

  // Per-pin edge qualifier: IBOTH takes either edge, otherwise IPOL picks rise (1) or fall (0).
  function automatic logic [7:0] edge_sel(input logic [7:0] in_v,
                                          input logic [7:0] prev_v,
                                          input logic [7:0] ipol,
                                          input logic [7:0] iboth);
    logic [7:0] rise;
    logic [7:0] fall;
    rise = in_v & ~prev_v;
    fall = ~in_v & prev_v;
    return (iboth & (rise | fall)) | (~iboth & ((ipol & rise) | (~ipol & fall)));
  endfunction

endpackage

// File: rtl/gpio_irq_port.sv
// One 8-bit GPIO port: control registers, input synchroniser, edge detect and
// sticky interrupt status with write-1-to-clear.
module gpio_irq_port
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [REG_W-1:0] reg_sel,
  input  logic [7:0]       din,
  input  logic             arm,
  input  logic [7:0]       pin_i,
  output logic [7:0]       rd_data,
  output logic [7:0]       out_o,
  output logic [7:0]       dir_o,
  output logic             pending_o
);

  logic [7:0] out_q, out_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] ien_q, ien_d;
  logic [7:0] ipol_q, ipol_d;
  logic [7:0] istat_q, istat_d;
  logic [7:0] iboth_q, iboth_d;
  logic [7:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;

  logic [7:0] in_val;
  logic [7:0] w1c;

  assign in_val = sync_q[SYNC_STAGES-1];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    ipol_d  = ipol_q;
    iboth_d = iboth_q;
    w1c     = '0;
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
    prev_d  = in_val;

    if (wr_en) begin
      case (reg_sel)
        REG_OUT:   out_d   = din;
        REG_DIR:   dir_d   = din;
        REG_IEN:   ien_d   = din;
        REG_IPOL:  ipol_d  = din;
        REG_ISTAT: w1c     = din;
        REG_IBOTH: iboth_d = din;
        default:   ;
      endcase
    end

    // A fresh edge is ORed in after the clear, so a same-cycle set beats W1C.
    istat_d = (istat_q & ~w1c) | (arm ? edge_sel(in_val, prev_q, ipol_q, iboth_q) : 8'h00);
  end

  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      REG_OUT:   rd_data = out_q;
      REG_DIR:   rd_data = dir_q;
      REG_IN:    rd_data = in_val;
      REG_IEN:   rd_data = ien_q;
      REG_IPOL:  rd_data = ipol_q;
      REG_ISTAT: rd_data = istat_q;
      REG_IBOTH: rd_data = iboth_q;
      default:   rd_data = 8'h00;
    endcase
  end

  // NOTE: the synchroniser flops are reset along with the registers so pads held high through reset look like a rise the arm counter can mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      ipol_q  <= '0;
      istat_q <= '0;
      iboth_q <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, which the synchroniser shift relies on.
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      ipol_q  <= ipol_d;
      istat_q <= istat_d;
      iboth_q <= iboth_d;
      prev_q  <= prev_d;
      sync_q  <= sync_d;
    end
  end

  assign out_o     = out_q;
  assign dir_o     = dir_q;
  assign pending_o = |(istat_q & ien_q);

endmodule

// File: rtl/gpio_irq_bank.sv
// NPORTS-wide GPIO bank on the CPU bus: address decode, registered read data,
// post-reset arm counter and a single registered IRQ.
module gpio_irq_bank
  import gpio_irq_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                we,
  input  logic [5:0]          addr,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                irq,
  input  logic [8*NPORTS-1:0] gpio_i,
  output logic [8*NPORTS-1:0] gpio_o,
  output logic [8*NPORTS-1:0] gpio_oe
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  // Wide enough to hold the terminal count for every legal SYNC_STAGES.
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [PORT_W-1:0] port_sel;
  logic [REG_W-1:0]  reg_sel;
  logic [7:0]        rd_data [NPORTS];
  logic [NPORTS-1:0] pending;
  logic [7:0]        rd_sel;
  logic              armed;

  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [7:0]       dout_q, dout_d;
  logic             irq_q, irq_d;

  assign port_sel = addr[PORT_W+REG_W-1:REG_W];
  assign reg_sel  = addr[REG_W-1:0];
  assign armed    = (arm_cnt_q == ARM_W'(ARM_MAX));

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    gpio_irq_port #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (cs && we && (port_sel == PORT_W'(p))),
      .reg_sel   (reg_sel),
      .din       (din),
      .arm       (armed),
      .pin_i     (gpio_i[8*p +: 8]),
      .rd_data   (rd_data[p]),
      .out_o     (gpio_o[8*p +: 8]),
      .dir_o     (gpio_oe[8*p +: 8]),
      .pending_o (pending[p])
    );
  end

  always_comb begin
    rd_sel = 8'h00;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_sel == PORT_W'(p)) rd_sel = rd_data[p];
    end
    dout_d    = (cs && !we) ? rd_sel : 8'h00;
    irq_d     = |pending;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q    <= '0;
      irq_q     <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      dout_q    <= dout_d;
      irq_q     <= irq_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_gpio_irq_bank.sv
// Scoreboard bench for gpio_irq_bank: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_gpio_irq_bank;

  localparam int NP = 2;
  localparam int S  = 2;
  localparam int GW = 8 * NP;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic [5:0]    addr = '0;
  logic [7:0]    din = '0;
  logic [7:0]    dout;
  logic          irq;
  logic [GW-1:0] gpio_i = '0;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] gpio_oe;

  gpio_irq_bank #(.NPORTS(NP), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .irq     (irq),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_DOUT, K_IRQ, K_GO, K_GOE} kind_e;
  typedef struct {
    kind_e         kind;
    logic [GW-1:0] exp;
  } exp_t;

  exp_t sb[$];

  logic [7:0]    m_out [NP];
  logic [7:0]    m_dir [NP];
  logic [7:0]    m_ien [NP];
  logic [7:0]    m_ipol [NP];
  logic [7:0]    m_istat [NP];
  logic [7:0]    m_iboth [NP];
  logic [GW-1:0] hist[$];   // pin vector sampled at edge n is hist[n-1]
  int            m_edges;

  task automatic m_clear();
    for (int p = 0; p < NP; p++) begin
      m_out[p] = 0; m_dir[p] = 0; m_ien[p] = 0;
      m_ipol[p] = 0; m_istat[p] = 0; m_iboth[p] = 0;
    end
    hist.delete();
    m_edges = 0;
  endtask

  function automatic logic [GW-1:0] pins_at(int m);
    if (m < 1 || m > hist.size()) return '0;
    return hist[m-1];
  endfunction

  function automatic logic [7:0] m_read(int p, int r, logic [GW-1:0] in_v);
    if (p >= NP) return 8'h00;
    case (r)
      0: return m_out[p];
      1: return m_dir[p];
      2: return in_v[8*p +: 8];
      3: return m_ien[p];
      4: return m_ipol[p];
      5: return m_istat[p];
      6: return m_iboth[p];
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_clear();
        sb.delete();
      end else begin
        int n, port, rg;
        bit armed, any;
        logic [GW-1:0] in_now, in_prv, vo, voe;
        logic [7:0] rise, fall, ev, clr;
        n      = m_edges + 1;
        in_now = pins_at(n - S);       // IN value visible just before this edge
        in_prv = pins_at(n - S - 1);
        armed  = (n - 1) >= (S + 1);
        port   = int'(addr[5:3]);
        rg     = int'(addr[2:0]);
        if (cs && !we) sb.push_back('{K_DOUT, GW'(m_read(port, rg, in_now))});
        any = 0;
        for (int p = 0; p < NP; p++) if ((m_istat[p] & m_ien[p]) != 0) any = 1;
        sb.push_back('{K_IRQ, GW'(any)});
        for (int p = 0; p < NP; p++) begin
          rise = in_now[8*p +: 8] & ~in_prv[8*p +: 8];
          fall = ~in_now[8*p +: 8] & in_prv[8*p +: 8];
          ev = 0;
          for (int b = 0; b < 8; b++)
            ev[b] = m_iboth[p][b] ? (rise[b] | fall[b]) : (m_ipol[p][b] ? rise[b] : fall[b]);
          clr = (cs && we && port == p && rg == 5) ? din : 8'h00;
          m_istat[p] = (m_istat[p] & ~clr) | (armed ? ev : 8'h00);
        end
        if (cs && we && port < NP) begin
          case (rg)
            0: m_out[port] = din;
            1: m_dir[port] = din;
            3: m_ien[port] = din;
            4: m_ipol[port] = din;
            6: m_iboth[port] = din;
            default: ;
          endcase
        end
        if (cs && we) begin
          for (int p = 0; p < NP; p++) begin
            vo[8*p +: 8]  = m_out[p];
            voe[8*p +: 8] = m_dir[p];
          end
          sb.push_back('{K_GO, vo});
          sb.push_back('{K_GOE, voe});
        end
        hist.push_back(gpio_i);
        m_edges = n;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        case (e.kind)
          K_DOUT:  check("sb_dout", 64'(dout), 64'(e.exp));
          K_IRQ:   check("sb_irq", 64'(irq), 64'(e.exp));
          K_GO:    check("sb_gpio_o", 64'(gpio_o), 64'(e.exp));
          default: check("sb_gpio_oe", 64'(gpio_oe), 64'(e.exp));
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    cs = 0; we = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input int p, input int r, input logic [7:0] d);
    cs = 1; we = 1; addr = {3'(p), 3'(r)}; din = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask

  task automatic bus_read(input int p, input int r);
    cs = 1; we = 0; addr = {3'(p), 3'(r)};
    @(negedge clk);
    cs = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_gpio_o", 64'(gpio_o), 64'h0);
    check("rst_gpio_oe", 64'(gpio_oe), 64'h0);

    // Pins high through reset: no spurious rise even with both edges enabled
    gpio_i = '1;
    reset  = 1;
    bus_write(0, 6, 8'hFF);
    bus_write(0, 3, 8'hFF);
    idle(10);
    bus_read(0, 2);
    check("arm_in", 64'(dout), 64'hFF);
    bus_read(0, 5);
    check("arm_istat", 64'(dout), 64'h00);
    check("arm_irq", 64'(irq), 64'h0);

    // Direction / output on port 1
    bus_write(1, 1, 8'h0F);
    bus_write(1, 0, 8'hA5);
    check("oe_p1", 64'(gpio_oe[15:8]), 64'h0F);
    check("out_p1", 64'(gpio_o[15:8]), 64'hA5);
    bus_read(1, 0);
    check("rd_out_p1", 64'(dout), 64'hA5);

    // Rising-edge interrupt on pin 0 with latency and W1C
    bus_write(0, 6, 8'h00);
    bus_write(0, 3, 8'h00);
    gpio_i = '0;
    idle(4);
    bus_write(0, 5, 8'hFF);
    bus_write(1, 5, 8'hFF);
    bus_write(0, 3, 8'h01);
    bus_write(0, 4, 8'h01);
    idle(2);
    gpio_i[0] = 1'b1;              // sampled at edge k
    @(negedge clk);                // after k
    @(negedge clk);                // after k+1
    @(negedge clk);                // after k+2
    check("lat_irq_k2", 64'(irq), 64'h0);
    bus_read(0, 5);                // edge k+3
    check("lat_istat", 64'(dout), 64'h01);
    check("lat_irq_k3", 64'(irq), 64'h1);
    bus_write(0, 5, 8'h01);
    check("w1c_irq_same", 64'(irq), 64'h1);
    @(negedge clk);
    check("w1c_irq_after", 64'(irq), 64'h0);

    // Either-edge on pin 1
    bus_write(0, 6, 8'h02);
    gpio_i[1] = 1'b1;              // edge k
    idle(4);
    bus_read(0, 5);                // k+4
    check("both_rise", 64'(dout), 64'h02);
    gpio_i[1] = 1'b0;
    bus_write(0, 5, 8'h02);        // k+5, pin high for 5 samples
    bus_read(0, 5);
    check("both_cleared", 64'(dout), 64'h00);
    idle(1);
    bus_read(0, 5);
    check("both_fall", 64'(dout), 64'h02);

    // Same-cycle set and W1C: set wins
    bus_write(0, 3, 8'h03);
    bus_write(0, 5, 8'h02);
    idle(2);
    gpio_i[1] = 1'b1;              // edge k
    @(negedge clk);
    @(negedge clk);
    bus_write(0, 5, 8'h02);        // edge k+2 coincides with set
    idle(1);
    check("coll_irq", 64'(irq), 64'h1);
    bus_read(0, 5);
    check("coll_istat", 64'(dout), 64'h02);
    bus_write(0, 5, 8'hFF);

    // Unimplemented port
    bus_write(3, 0, 8'h5A);
    bus_read(3, 0);
    check("hole_rd", 64'(dout), 64'h00);
    check("hole_gpio_o", 64'(gpio_o), 64'hA500);

    // Randomised traffic checked by the model
    for (int i = 0; i < 1500; i++) begin
      gpio_i ^= GW'($urandom & $urandom & $urandom);
      cs   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      din  = 8'($urandom);
      @(negedge clk);
    end
    idle(2);

    // Reset mid-operation with irq pending and outputs driven
    bus_write(1, 1, 8'h0F);
    bus_write(1, 0, 8'hA5);
    bus_write(0, 6, 8'hFF);
    bus_write(0, 3, 8'hFF);
    gpio_i[7:0] = ~gpio_i[7:0];
    idle(5);
    check("pre_rst_irq", 64'(irq), 64'h1);
    cs = 1; we = 0; addr = {3'd1, 3'd0};
    @(posedge clk);
    #1;
    check("pre_rst_dout", 64'(dout), 64'hA5);
    reset = 0;
    #1;
    check("mid_rst_irq", 64'(irq), 64'h0);
    check("mid_rst_oe", 64'(gpio_oe), 64'h0);
    check("mid_rst_dout", 64'(dout), 64'h0);
    cs = 0;
    @(negedge clk);
    reset = 1;
    idle(3);
    bus_read(1, 0);
    check("post_rst_out", 64'(dout), 64'h00);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
